// File: rtl/game_cmd_input.sv
`default_nettype none
// ============================================================================
// Module      : game_cmd_input
// Description : Synchronises, debounces and edge-detects game buttons and the
//               collision flag, then arbitrates them into one-cycle commands.
// Revision    : 1.0 - initial release
// ============================================================================
module game_cmd_input #(
    parameter int DB_TICKS = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_resume,
    input  logic       hit,
    output logic       start,
    output logic       pause,
    output logic       resume,
    output logic       die,
    output logic [3:0] pending
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Bit order everywhere below matches pending: {die/hit, start, pause, resume}
    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_lvl;
    logic [3:0] r_lvl_d;
    logic [3:0] w_rise;
    logic [3:0] w_grant;
    logic [3:0] w_clear;
    logic [3:0] r_pending;
    logic [3:0] r_out;

    assign w_raw = {hit, btn_start, btn_pause, btn_resume};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lvl[3] = r_sync2[3];

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic             r_lvl;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_lvl <= 1'b0;
                    r_cnt <= '0;
                end else if (sample_tick) begin
                    if (r_sync2[i] != r_lvl) begin
                        if (r_cnt == c_cnt_last) begin
                            r_lvl <= ~r_lvl;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_lvl[i] = r_lvl;
        end
    endgenerate

    assign w_rise = w_lvl & ~r_lvl_d;

    always_comb begin
        w_grant = '0;
        if (r_pending[3])      w_grant[3] = 1'b1;
        else if (r_pending[2]) w_grant[2] = 1'b1;
        else if (r_pending[1]) w_grant[1] = 1'b1;
        else if (r_pending[0]) w_grant[0] = 1'b1;
    end

    // A die grant also flushes pause/resume; start survives to restart the game
    assign w_clear = w_grant | (w_grant[3] ? 4'b0011 : 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl_d   <= '0;
            r_pending <= '0;
            r_out     <= '0;
        end else begin
            r_lvl_d   <= w_lvl;
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_out     <= w_grant;
        end
    end

    assign {die, start, pause, resume} = r_out;
    assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_game_cmd_input.sv
`default_nettype none
// Testbench for game_cmd_input: directed scenarios plus random stimulus,
// all checked cycle-by-cycle against a behavioural reference model.
module tb_game_cmd_input;

    localparam int DB_TICKS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       btn_start, btn_pause, btn_resume, hit;
    logic       start, pause, resume, die;
    logic [3:0] pending;

    game_cmd_input #(.DB_TICKS(DB_TICKS), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_resume(btn_resume),
        .hit(hit), .start(start), .pause(pause), .resume(resume), .die(die),
        .pending(pending)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int phase = 0;
    int cyc = 0;
    int n_start, n_pause, n_resume, n_die;
    int t_start, t_pause, t_resume;

    // Reference model state; index 3 = hit/die, 2 = start, 1 = pause, 0 = resume
    logic [3:0] m_s1, m_s2, m_prev, m_pend, m_out;
    logic [2:0] m_lvl;
    int         m_cnt [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [3:0] cur;
        int g;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0; m_out = '0; m_lvl = '0;
            for (int b = 0; b < 3; b++) m_cnt[b] = 0;
        end else begin
            g = -1;
            for (int k = 3; k >= 0; k--) if (m_pend[k] && g < 0) g = k;
            for (int k = 0; k < 4; k++) m_out[k] = (k == g);
            cur = {m_s2[3], m_lvl};
            for (int k = 0; k < 4; k++)
                if (k == g || (g == 3 && k < 2)) m_pend[k] = 1'b0;
            for (int k = 0; k < 4; k++)
                if (cur[k] && !m_prev[k]) m_pend[k] = 1'b1;
            m_prev = cur;
            if (sample_tick) begin
                for (int b = 0; b < 3; b++) begin
                    if (m_s2[b] != m_lvl[b]) begin
                        m_cnt[b]++;
                        if (m_cnt[b] == DB_TICKS) begin
                            m_lvl[b] = ~m_lvl[b];
                            m_cnt[b] = 0;
                        end
                    end else begin
                        m_cnt[b] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = {hit, btn_start, btn_pause, btn_resume};
        end
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        cyc++;
        check("outputs", {28'd0, die, start, pause, resume}, {28'd0, m_out});
        check("pending", {28'd0, pending}, {28'd0, m_pend});
        check("onehot", ($countones({die, start, pause, resume}) <= 1), 1);
        if (start)  begin n_start++;  t_start  = cyc; end
        if (pause)  begin n_pause++;  t_pause  = cyc; end
        if (resume) begin n_resume++; t_resume = cyc; end
        if (die)    n_die++;
        phase++;
        sample_tick = (phase % 4 == 0);
    endtask

    task automatic clear_counts();
        n_start = 0; n_pause = 0; n_resume = 0; n_die = 0;
        t_start = 0; t_pause = 0; t_resume = 0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; sample_tick = 1'b0;
        btn_start = 1'b0; btn_pause = 1'b0; btn_resume = 1'b0; hit = 1'b0;
        clear_counts();
        repeat (3) cycle();
        check("rst_outputs", {28'd0, die, start, pause, resume}, 0);
        check("rst_pending", {28'd0, pending}, 0);
        reset = 1'b0;

        // Clean press: one start pulse only, nothing on release
        clear_counts();
        btn_start = 1'b1;
        repeat (40) cycle();
        check("press_start_cnt", n_start, 1);
        check("press_pending", {28'd0, pending}, 0);
        btn_start = 1'b0;
        repeat (30) cycle();
        check("release_start_cnt", n_start, 1);

        // Bounce on pause: never stable for DB_TICKS samples
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            btn_pause = ((i / 3) % 2 == 0);
            cycle();
        end
        btn_pause = 1'b0;
        repeat (30) cycle();
        check("bounce_pause_cnt", n_pause, 0);

        // Collision: die exactly 4 edges after raw rise
        clear_counts();
        hit = 1'b1;
        cycle(); cycle();
        hit = 1'b0;
        cycle();
        check("hit_no_early_die", {31'd0, die}, 0);
        cycle();
        check("hit_die_edge4", {31'd0, die}, 1);
        repeat (6) cycle();
        check("hit_die_cnt", n_die, 1);
        clear_counts();
        hit = 1'b1;
        repeat (30) cycle();
        hit = 1'b0;
        repeat (6) cycle();
        check("held_hit_die_cnt", n_die, 1);

        // Simultaneous presses: start, pause, resume on consecutive cycles
        clear_counts();
        btn_start = 1'b1; btn_pause = 1'b1; btn_resume = 1'b1;
        repeat (40) cycle();
        check("simul_start", n_start, 1);
        check("simul_pause", n_pause, 1);
        check("simul_resume", n_resume, 1);
        check("simul_pause_after_start", t_pause - t_start, 1);
        check("simul_resume_after_pause", t_resume - t_pause, 1);
        btn_start = 1'b0; btn_pause = 1'b0; btn_resume = 1'b0;
        repeat (40) cycle();

        // die flush: hit edge lands in the same cycle as pause/resume edges
        clear_counts();
        btn_pause = 1'b1; btn_resume = 1'b1;
        guard = 0;
        while (m_cnt[1] != DB_TICKS - 1 && guard < 100) begin
            cycle();
            guard++;
        end
        check("flush_align_timeout", (guard < 100), 1);
        cycle(); cycle();
        hit = 1'b1;
        repeat (20) cycle();
        hit = 1'b0;
        check("flush_die", n_die, 1);
        check("flush_pause", n_pause, 0);
        check("flush_resume", n_resume, 0);
        check("flush_pending", {28'd0, pending}, 0);
        btn_pause = 1'b0; btn_resume = 1'b0;
        repeat (40) cycle();
        check("flush_no_late_pulse", n_pause + n_resume, 0);

        // Reset mid-debounce with resume held through it
        clear_counts();
        btn_resume = 1'b1;
        guard = 0;
        while (m_cnt[0] != 2 && guard < 100) begin
            cycle();
            guard++;
        end
        check("rstmid_align_timeout", (guard < 100), 1);
        reset = 1'b1;
        cycle();
        check("rstmid_out0", {28'd0, die, start, pause, resume}, 0);
        check("rstmid_pend0", {28'd0, pending}, 0);
        cycle();
        check("rstmid_out1", {28'd0, die, start, pause, resume}, 0);
        check("rstmid_pend1", {28'd0, pending}, 0);
        reset = 1'b0;
        repeat (40) cycle();
        check("rstmid_resume_cnt", n_resume, 1);
        btn_resume = 1'b0;
        repeat (30) cycle();

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_start  = ~btn_start;
            if ($urandom_range(0, 15) == 0) btn_pause  = ~btn_pause;
            if ($urandom_range(0, 15) == 0) btn_resume = ~btn_resume;
            if ($urandom_range(0, 11) == 0) hit        = ~hit;
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
